// File: rtl/pipeline_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM state encoding,
// reset PC, the NOP encoding and the PC/instruction pair carried through IF.
package pipeline_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_word_t;

  localparam fetch_word_t FETCH_WORD_EMPTY = {32'h0000_0000, INSTR_NOP};

  // Sequential successor; wraps naturally at 2^32.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetch response that arrived while the IF/ID
// register was stalled; load and drain never coincide in normal operation.
module fetch_skid_buf
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        drain,
  input  fetch_word_t load_word,
  output logic        valid,
  output fetch_word_t word
);

  logic        valid_reg;
  fetch_word_t word_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      word_reg  <= FETCH_WORD_EMPTY;
    end else if (load) begin
      valid_reg <= 1'b1;
      word_reg  <= load_word;
    end else if (drain) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign word  = word_reg;

endmodule

// File: rtl/fetch_pc_unit.sv
// IF stage: owns the fetch PC, runs the single-outstanding imem handshake and
// holds the IF/ID register; branch redirects take effect after the delay slot.
module fetch_pc_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_is_branch,
  input  logic [31:0] id_branch_pc,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  fetch_state_t state_reg, state_next;
  logic         req_reg;
  logic [31:0]  pc_reg, pc_next;
  logic         pend_reg;
  logic [31:0]  redirect_pc_reg;
  logic         if_valid_reg;
  fetch_word_t  ifid_reg;

  logic         consume, commit_now, out_free;
  logic         load_direct, skid_load, skid_drain, update_event;
  logic         skid_valid;
  fetch_word_t  skid_word, resp_word;

  assign consume    = if_valid_reg & ~id_stall;
  assign commit_now = consume & id_is_branch;
  assign out_free   = ~if_valid_reg | ~id_stall;
  assign resp_word  = {pc_reg, imem_rdata};

  always_comb begin
    state_next  = state_reg;
    load_direct = 1'b0;
    skid_load   = 1'b0;
    skid_drain  = 1'b0;
    case (state_reg)
      S_REQ: begin
        if (req_reg && imem_gnt) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (out_free) begin
            load_direct = 1'b1;
            state_next  = S_REQ;
          end else begin
            skid_load  = 1'b1;
            state_next = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (!id_stall && skid_valid) begin
          skid_drain = 1'b1;
          state_next = S_REQ;
        end
      end
      default: state_next = S_REQ;
    endcase
  end

  assign update_event = load_direct | skid_drain;

  // A commit landing on the update cycle is forwarded directly instead of
  // being parked in the pending register.
  always_comb begin
    pc_next = pc_reg;
    if (update_event) begin
      if (commit_now)    pc_next = id_branch_pc;
      else if (pend_reg) pc_next = redirect_pc_reg;
      else               pc_next = next_seq_pc(pc_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= S_REQ;
      req_reg         <= 1'b0;
      pc_reg          <= RESET_PC;
      pend_reg        <= 1'b0;
      redirect_pc_reg <= 32'h0000_0000;
    end else begin
      state_reg <= state_next;
      req_reg   <= (state_next == S_REQ);
      pc_reg    <= pc_next;
      if (update_event) begin
        pend_reg <= 1'b0;
      end else if (commit_now) begin
        pend_reg        <= 1'b1;
        redirect_pc_reg <= id_branch_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_valid_reg <= 1'b0;
      ifid_reg     <= FETCH_WORD_EMPTY;
    end else if (load_direct) begin
      if_valid_reg <= 1'b1;
      ifid_reg     <= resp_word;
    end else if (skid_drain) begin
      if_valid_reg <= 1'b1;
      ifid_reg     <= skid_word;
    end else if (consume) begin
      if_valid_reg <= 1'b0;
    end
  end

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .drain     (skid_drain),
    .load_word (resp_word),
    .valid     (skid_valid),
    .word      (skid_word)
  );

  assign imem_req  = req_reg;
  assign imem_addr = pc_reg;
  assign pc_out    = pc_reg;
  assign if_valid  = if_valid_reg;
  assign if_pc     = ifid_reg.pc;
  assign if_instr  = ifid_reg.instr;

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch front end of the five-stage MIPS pipeline: owns the architectural fetch PC, runs the request/response handshake to instruction memory, and holds the fetched word in the IF/ID register. It consumes the branch/jump redirect produced by the ID-stage branch resolver. It supplies that resolver with the delay-slot PC and the ID-stage instruction, and applies the redirect after the delay-slot fetch, honouring MIPS delay-slot semantics.

## Interface
- RESET_PC, 32'h0040_0000, first fetch address after reset
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset; synchronous, active-low
- id_is_branch  in  1  redirect request from branch resolver (combinational on if_instr)
- id_branch_pc  in  32  redirect target
- id_stall  in  1  ID cannot accept; IF/ID contents must hold
- imem_req  out  1  fetch request (registered)
- imem_addr  out  32  fetch address, equals pc_out
- imem_gnt  in  1  memory accepted request this cycle
- imem_rvalid  in  1  response valid, exactly one per grant, ≥1 cycle after gnt
- imem_rdata  in  32  instruction word
- pc_out  out  32  address of the in-flight/most recent fetch (delay-slot PC to resolver)
- if_valid  out  1  IF/ID register holds an instruction
- if_pc  out  32  PC of IF/ID instruction
- if_instr  out  32  IF/ID instruction (ID-stage instr to resolver)

## Operation
- States: S_REQ (imem_req=1), S_WAIT (one fetch outstanding), S_FULL (response parked in skid, output stalled). At most one outstanding fetch.
- S_REQ: imem_gnt → S_WAIT; else hold request, address stable.
- S_WAIT, rvalid: if output free (~if_valid | ~id_stall) → word loads IF/ID (if_pc=pc_out), PC update event, → S_REQ; else word loads skid → S_FULL.
- S_FULL: when ~id_stall → skid loads IF/ID, PC update event, → S_REQ.
- IF/ID consumed when if_valid & ~id_stall; if no new word loads that cycle, if_valid←0.
- Branch commit = if_valid & ~id_stall & id_is_branch. Commit latches redirect_pending←1, redirect_pc←id_branch_pc.
- PC update event: pc ← commit_now ? id_branch_pc : redirect_pending ? redirect_pc : pc+4 (mod 2^32, wraps); clears redirect_pending. Commit coincident with update event is bypassed, not latched.
- Delay-slot rule: instruction at pc_out at commit time is never squashed; redirect affects the next fetch only.
- Second commit before update (branch in delay slot, architecturally undefined): last wins.
- Target alignment not checked; id_branch_pc[1:0] passed through.

## Timing
- Reset values: imem_req=0, pc_out=RESET_PC, if_valid=0, if_pc=0, if_instr=0, pending=0, state S_REQ.
- First cycle after rst_n deasserts: imem_req=1, imem_addr=RESET_PC.
- Best case (gnt same cycle as req, rvalid next): req at t, rvalid t+1, if_valid t+2 with next req at t+2; throughput one instruction per 2 cycles.
- Reset asserted mid-operation: all state cleared next edge; imem shares rst_n, so no stale response arrives.
- id_stall while S_REQ/S_WAIT does not block issue; only blocks loading IF/ID.

## Structure
- Shared package pipeline_pkg: state enum (S_REQ, S_WAIT, S_FULL), RESET_PC default, INSTR_NOP constant.
- One sub-module: fetch_skid_buf (one-entry pc/instr buffer with valid, load, drain).

## Test plan
- Reset release, gnt immediate, rvalid +1, no stall → addresses 0x00400000, 0x00400004, 0x00400008 fetched; if_valid pulses every 2nd cycle with matching if_pc.
- Branch at 0x00400000 committing while 0x00400004 outstanding, target 0x00400100 → 0x00400004 delivered, next imem_addr=0x00400100.
- id_stall held 5 cycles with full IF/ID, response arrives → parked in skid, imem_req stays 0, on release both words delivered in order, no loss/duplication.
- Commit coincident with skid drain, target 0x00400200 → bypass used, next imem_addr=0x00400200, pending stays 0.
- imem_gnt withheld 4 cycles → imem_addr stable, single request; pc=0xFFFFFFFC +4 → next address 0x00000000.
- rst_n low during S_WAIT → next cycle all outputs at reset values, restart at RESET_PC.
